// File: rtl/slave_wr_buffer.sv
// ---------------------------------------------------------------------------
// slave_wr_buffer
//
// Posted-write buffer placed between one cross-bar slave port (upstream) and a
// slave memory (downstream). Writes are acknowledged as soon as they are stored
// in a DEPTH-entry FIFO and are drained to the memory in the background. Reads
// wait until the FIFO is empty, so a read always observes every earlier write.
//
// Handshake (both sides): the requester raises req with addr/cmd/wdata and
// keeps all of them stable up to and including the cycle in which ack is high.
// The responder raises ack for exactly one cycle. In the cycle after ack the
// requester may drop req or present a new request.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   xbar_req/addr/cmd/wdata  upstream request (cmd 1 = write, 0 = read)
//   xbar_ack, xbar_rdata     upstream one-cycle ack and read data
//   ram_req/addr/cmd/wdata   downstream request
//   ram_ack, ram_rdata       downstream one-cycle ack and read data
//   wbuf_level, wbuf_empty   FIFO occupancy
//   o_dbg_u_state            upstream FSM state (debug)
//   o_dbg_d_state            downstream FSM state (debug)
// ---------------------------------------------------------------------------
module slave_wr_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      xbar_req,
    input  logic [AW-1:0]             xbar_addr,
    input  logic                      xbar_cmd,
    input  logic [DW-1:0]             xbar_wdata,
    output logic                      xbar_ack,
    output logic [DW-1:0]             xbar_rdata,
    output logic                      ram_req,
    output logic [AW-1:0]             ram_addr,
    output logic                      ram_cmd,
    output logic [DW-1:0]             ram_wdata,
    input  logic                      ram_ack,
    input  logic [DW-1:0]             ram_rdata,
    output logic [$clog2(DEPTH):0]    wbuf_level,
    output logic                      wbuf_empty,
    output logic [2:0]                o_dbg_u_state,
    output logic [1:0]                o_dbg_d_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [2:0] {
        U_IDLE  = 3'd0,
        U_WFULL = 3'd1,
        U_RWAIT = 3'd2,
        U_RBUSY = 3'd3,
        U_ACK   = 3'd4
    } u_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WR   = 2'd1,
        D_RD   = 2'd2,
        D_GAP  = 2'd3
    } d_state_t;

    u_state_t        r_u_state;
    d_state_t        r_d_state;

    logic [AW-1:0]   r_mem_addr [DEPTH];
    logic [DW-1:0]   r_mem_data [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_empty;

    logic            r_xbar_ack;
    logic [DW-1:0]   r_xbar_rdata;
    logic            r_ram_req;
    logic [AW-1:0]   r_ram_addr;
    logic            r_ram_cmd;
    logic [DW-1:0]   r_ram_wdata;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_rd_issue;
    logic [LW-1:0]   w_level_nxt;

    // Fullness is judged on the registered level only, so a pop in the same
    // cycle never admits a push; the write waiting in U_WFULL goes next cycle.
    assign w_full = (r_level == LW'(DEPTH));

    // In U_WFULL the upstream write is still held, so no need to look at req.
    assign w_push = !w_full &&
                    (((r_u_state == U_IDLE) && xbar_req && xbar_cmd) ||
                     (r_u_state == U_WFULL));

    assign w_pop = (r_d_state == D_WR) && ram_ack;

    // A read is handed downstream only once all buffered writes are gone and
    // the downstream side is fully idle (not in its post-transaction gap).
    assign w_rd_issue = (r_u_state == U_RWAIT) && r_empty && (r_d_state == D_IDLE);

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // FIFO storage: contents need no reset, occupancy tracking does.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= xbar_addr;
            r_mem_data[r_wptr] <= xbar_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Upstream FSM: accepts requests from the cross-bar and returns the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_u_state    <= U_IDLE;
            r_xbar_ack   <= 1'b0;
            r_xbar_rdata <= '0;
        end else begin
            r_xbar_ack <= 1'b0;
            case (r_u_state)
                U_IDLE: begin
                    if (xbar_req) begin
                        if (xbar_cmd) begin
                            if (!w_full) begin
                                r_xbar_ack <= 1'b1;
                                r_u_state  <= U_ACK;
                            end else begin
                                r_u_state  <= U_WFULL;
                            end
                        end else begin
                            r_u_state <= U_RWAIT;
                        end
                    end
                end
                U_WFULL: begin
                    if (!w_full) begin
                        r_xbar_ack <= 1'b1;
                        r_u_state  <= U_ACK;
                    end
                end
                U_RWAIT: begin
                    if (w_rd_issue) begin
                        r_u_state <= U_RBUSY;
                    end
                end
                U_RBUSY: begin
                    // Only the read is outstanding here, so ram_ack is ours.
                    if (ram_ack) begin
                        r_xbar_rdata <= ram_rdata;
                        r_xbar_ack   <= 1'b1;
                        r_u_state    <= U_ACK;
                    end
                end
                U_ACK: begin
                    r_u_state <= U_IDLE;
                end
                default: begin
                    r_u_state <= U_IDLE;
                end
            endcase
        end
    end

    // Downstream FSM: drains the FIFO head, or runs the single pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_state   <= D_IDLE;
            r_ram_req   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_cmd   <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            case (r_d_state)
                // D_GAP is the one cycle with ram_req low after a transaction;
                // it makes the same dispatch decision as D_IDLE for buffered
                // writes so a backlog drains with exactly one idle cycle between
                // requests. Reads are only issued from D_IDLE.
                D_IDLE, D_GAP: begin
                    if (!r_empty) begin
                        r_ram_req   <= 1'b1;
                        r_ram_cmd   <= 1'b1;
                        r_ram_addr  <= r_mem_addr[r_rptr];
                        r_ram_wdata <= r_mem_data[r_rptr];
                        r_d_state   <= D_WR;
                    end else if (w_rd_issue) begin
                        r_ram_req   <= 1'b1;
                        r_ram_cmd   <= 1'b0;
                        r_ram_addr  <= xbar_addr;
                        r_ram_wdata <= '0;
                        r_d_state   <= D_RD;
                    end else begin
                        r_d_state   <= D_IDLE;
                    end
                end
                D_WR, D_RD: begin
                    if (ram_ack) begin
                        r_ram_req <= 1'b0;
                        r_d_state <= D_GAP;
                    end
                end
                default: begin
                    r_d_state <= D_IDLE;
                end
            endcase
        end
    end

    assign xbar_ack      = r_xbar_ack;
    assign xbar_rdata    = r_xbar_rdata;
    assign ram_req       = r_ram_req;
    assign ram_addr      = r_ram_addr;
    assign ram_cmd       = r_ram_cmd;
    assign ram_wdata     = r_ram_wdata;
    assign wbuf_level    = r_level;
    assign wbuf_empty    = r_empty;
    assign o_dbg_u_state = r_u_state;
    assign o_dbg_d_state = r_d_state;

endmodule
